// File: rtl/p4_router_egr_demux.sv
// Egress demux: pairs each VNP4 packet with its out-of-band metadata word and
// steers the whole packet to one egress port, or drops it when the port is invalid or disabled.

module p4_router_egr_demux_lane #(
  parameter int          SEL_W = 8,
  parameter int unsigned IDX   = 0
) (
  input  logic [SEL_W-1:0] head_sel,
  input  logic [SEL_W-1:0] cur_sel,
  input  logic             port_en,
  input  logic             fwd,
  input  logic             s_tvalid,
  input  logic             m_tready,
  output logic             head_hit,
  output logic             m_tvalid,
  output logic             rdy
);
  logic cur_hit;

  assign head_hit = (32'(head_sel) == IDX) && port_en;
  assign cur_hit  = fwd && (32'(cur_sel) == IDX);
  assign m_tvalid = cur_hit && s_tvalid;
  assign rdy      = cur_hit && m_tready;
endmodule

module p4_router_egr_demux #(
  parameter int DATA_BYTES                   = 8,
  parameter int NUM_EGR_PORTS                = 4,
  parameter int USER_METADATA_WIDTH          = 16,
  parameter int ING_PHYS_PORT_METADATA_WIDTH = 8,
  parameter int MD_FIFO_DEPTH                = 4
) (
  input  logic                           clk,
  input  logic                           aresetn,
  input  logic [NUM_EGR_PORTS-1:0]       port_enable,
  input  logic [USER_METADATA_WIDTH-1:0] md_in,
  input  logic                           md_in_valid,
  input  logic [8*DATA_BYTES-1:0]        s_tdata,
  input  logic [DATA_BYTES-1:0]          s_tkeep,
  input  logic                           s_tlast,
  input  logic                           s_tvalid,
  output logic                           s_tready,
  output logic [8*DATA_BYTES-1:0]        m_tdata,
  output logic [DATA_BYTES-1:0]          m_tkeep,
  output logic                           m_tlast,
  output logic [NUM_EGR_PORTS-1:0]       m_tvalid,
  input  logic [NUM_EGR_PORTS-1:0]       m_tready,
  output logic                           drop_pulse,
  output logic [31:0]                    drop_count,
  output logic                           md_overflow
);
  localparam int SEL_W = USER_METADATA_WIDTH - ING_PHYS_PORT_METADATA_WIDTH;
  localparam int PTR_W = $clog2(MD_FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  state_t                   state;
  logic [SEL_W-1:0]         md_mem [MD_FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [PTR_W:0]           md_cnt;
  logic [SEL_W-1:0]         cur_sel, head_sel;
  logic                     fifo_full, push, pop, fwd, beat_done;
  logic [NUM_EGR_PORTS-1:0] head_hit, cur_rdy;
  logic                     unused_ing;

  // Ingress-port bits travel with the metadata but play no part in egress steering.
  assign unused_ing  = ^md_in[ING_PHYS_PORT_METADATA_WIDTH-1:0];

  assign fifo_full   = md_cnt == (PTR_W+1)'(MD_FIFO_DEPTH);
  assign pop         = (state == IDLE) && (md_cnt != '0);
  assign push        = md_in_valid && (!fifo_full || pop);
  assign md_overflow = md_in_valid && fifo_full && !pop;
  assign head_sel    = md_mem[rd_ptr];
  assign fwd         = state == FWD;

  for (genvar i = 0; i < NUM_EGR_PORTS; i++) begin : g_lane
    p4_router_egr_demux_lane #(.SEL_W(SEL_W), .IDX(i)) u_lane (
      .head_sel (head_sel),
      .cur_sel  (cur_sel),
      .port_en  (port_enable[i]),
      .fwd      (fwd),
      .s_tvalid (s_tvalid),
      .m_tready (m_tready[i]),
      .head_hit (head_hit[i]),
      .m_tvalid (m_tvalid[i]),
      .rdy      (cur_rdy[i])
    );
  end

  assign s_tready   = (state == DROP) || (|cur_rdy);
  assign beat_done  = s_tvalid && s_tready && s_tlast;
  assign drop_pulse = (state == DROP) && beat_done;
  assign m_tdata    = s_tdata;
  assign m_tkeep    = s_tkeep;
  assign m_tlast    = s_tlast;

  always_ff @(posedge clk) begin
    if (push) md_mem[wr_ptr] <= md_in[USER_METADATA_WIDTH-1:ING_PHYS_PORT_METADATA_WIDTH];
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      md_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   md_cnt <= md_cnt + 1'b1;
        2'b01:   md_cnt <= md_cnt - 1'b1;
        default: md_cnt <= md_cnt;
      endcase
    end
  end

  // Destination validity is frozen at pop; later enable changes affect only the next packet.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      cur_sel    <= '0;
      drop_count <= '0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          cur_sel <= head_sel;
          state   <= (|head_hit) ? FWD : DROP;
        end
        FWD:  if (beat_done) state <= IDLE;
        DROP: if (beat_done) begin
          state <= IDLE;
          if (drop_count != '1) drop_count <= drop_count + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_p4_router_egr_demux.sv
// Randomized + directed bench for p4_router_egr_demux against a packet-level scoreboard.
module tb_p4_router_egr_demux;
  localparam int DB = 8, NP = 4, UMW = 16, IPW = 8, DEPTH = 4;

  logic             clk = 0, aresetn = 0;
  logic [NP-1:0]    port_enable = '1, m_tvalid, m_tready = '1;
  logic [UMW-1:0]   md_in = '0;
  logic             md_in_valid = 0;
  logic [8*DB-1:0]  s_tdata = '0, m_tdata;
  logic [DB-1:0]    s_tkeep = '0, m_tkeep;
  logic             s_tlast = 0, s_tvalid = 0, s_tready, m_tlast;
  logic             drop_pulse, md_overflow;
  logic [31:0]      drop_count;

  always #5 clk = ~clk;

  p4_router_egr_demux #(
    .DATA_BYTES(DB), .NUM_EGR_PORTS(NP), .USER_METADATA_WIDTH(UMW),
    .ING_PHYS_PORT_METADATA_WIDTH(IPW), .MD_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .aresetn(aresetn), .port_enable(port_enable),
    .md_in(md_in), .md_in_valid(md_in_valid),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .drop_pulse(drop_pulse), .drop_count(drop_count), .md_overflow(md_overflow)
  );

  typedef struct packed {logic [63:0] d; logic [7:0] k; logic l;} beat_t;
  typedef beat_t pkt_t[$];

  beat_t exp_q [NP][$];
  int    n_chk = 0, n_err = 0, exp_drops = 0, drop_seen = 0, ovf_seen = 0;
  int    obs_cnt [NP];
  bit    rdy_rand = 0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted beat on a port must be the next expected beat for that port.
  always @(negedge clk) if (aresetn) begin
    chk("onehot_tvalid", 96'($countones(m_tvalid) <= 1), 96'(1));
    for (int i = 0; i < NP; i++) if (m_tvalid[i] && m_tready[i]) begin
      obs_cnt[i]++;
      if (exp_q[i].size() == 0) chk($sformatf("unexpected_beat_p%0d", i), 96'(1), 96'(0));
      else chk($sformatf("beat_p%0d", i), 96'({m_tdata, m_tkeep, m_tlast}), 96'(exp_q[i].pop_front()));
    end
    if (drop_pulse)  drop_seen++;
    if (md_overflow) ovf_seen++;
  end

  initial forever begin
    @(posedge clk); #1;
    if (rdy_rand) m_tready = NP'($urandom);
  end

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic mk_pkt(input int nb, output pkt_t p);
    beat_t b;
    p = {};
    for (int j = 0; j < nb; j++) begin
      b.d = {$urandom, $urandom};
      b.l = (j == nb - 1);
      b.k = b.l ? (8'hFF >> $urandom_range(0, 7)) : 8'hFF;
      p.push_back(b);
    end
  endtask

  // Reference decision: forward iff port in range and enabled at the time metadata is consumed.
  task automatic expect_pkt(input int sel, input pkt_t p);
    bit ok;
    ok = 0;
    if (sel < NP) ok = port_enable[sel];
    if (ok) foreach (p[j]) exp_q[sel].push_back(p[j]);
    else exp_drops++;
  endtask

  task automatic drive_beat(input beat_t b, output int waits);
    waits = 0;
    s_tvalid = 1; s_tdata = b.d; s_tkeep = b.k; s_tlast = b.l;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      step(); waits++;
      if (waits > 300) begin chk("beat_timeout", 96'(waits), 96'(0)); break; end
    end
    step();
    s_tvalid = 0; s_tlast = 0;
  endtask

  task automatic drive_pkt(input pkt_t p, input bit bubbles);
    int w;
    foreach (p[j]) begin
      if (bubbles) repeat ($urandom_range(0, 2)) step();
      drive_beat(p[j], w);
    end
  endtask

  task automatic md_pulse(input int sel);
    md_in = {8'(sel), 8'($urandom)}; md_in_valid = 1;
    step();
    md_in_valid = 0;
  endtask

  task automatic send_rand();
    pkt_t p;
    int sel, d1, d2;
    sel = ($urandom_range(0, 9) == 0) ? 200 : $urandom_range(0, 6);
    d1 = $urandom_range(0, 5);
    d2 = $urandom_range(0, 5);
    mk_pkt($urandom_range(1, 5), p);
    expect_pkt(sel, p);
    fork
      begin repeat (d1) step(); md_pulse(sel); end
      begin repeat (d2) step(); drive_pkt(p, 1); end
    join
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NP; i++) n += exp_q[i].size();
    return n;
  endfunction

  initial begin
    pkt_t p;
    int   w, base;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_s_tready", 96'(s_tready), 96'(0));
    chk("rst_m_tvalid", 96'(m_tvalid), 96'(0));
    chk("rst_drop_count", 96'(drop_count), 96'(0));
    chk("rst_drop_pulse", 96'(drop_pulse), 96'(0));
    chk("rst_md_overflow", 96'(md_overflow), 96'(0));
    step(); aresetn = 1; step();

    // SEL=2, 3 beats, all ports enabled
    base = obs_cnt[2];
    mk_pkt(3, p); expect_pkt(2, p);
    md_pulse(2); drive_pkt(p, 0); step();
    chk("sel2_beats", 96'(obs_cnt[2] - base), 96'(3));
    chk("sel2_drop_count", 96'(drop_count), 96'(0));

    // SEL=5 out of range: dropped, s_tready high from the first DROP cycle
    mk_pkt(2, p); expect_pkt(5, p);
    md_pulse(5); step();
    drive_beat(p[0], w); chk("drop_rdy_b0", 96'(w), 96'(0));
    drive_beat(p[1], w); chk("drop_rdy_b1", 96'(w), 96'(0));
    step();
    chk("drop_count_1", 96'(drop_count), 96'(exp_drops));
    chk("drop_pulses_1", 96'(drop_seen), 96'(1));

    // Disabled port, enable restored mid-packet: still dropped
    port_enable = 4'b1101;
    mk_pkt(3, p); expect_pkt(1, p);
    md_pulse(1); step();
    drive_beat(p[0], w);
    port_enable = 4'b1111;
    drive_beat(p[1], w); drive_beat(p[2], w);
    step();
    chk("drop_count_2", 96'(drop_count), 96'(2));
    chk("drop_pulses_2", 96'(drop_seen), 96'(2));

    // Data 5 cycles ahead of its metadata
    mk_pkt(3, p); expect_pkt(3, p);
    s_tvalid = 1; s_tdata = p[0].d; s_tkeep = p[0].k; s_tlast = p[0].l;
    repeat (5) begin @(negedge clk); chk("early_data_stall", 96'(s_tready), 96'(0)); step(); end
    md_in = {8'd3, 8'h5A}; md_in_valid = 1;
    @(negedge clk); chk("push_cycle_stall", 96'(s_tready), 96'(0));
    step(); md_in_valid = 0;
    @(negedge clk); chk("pop_cycle_stall", 96'(s_tready), 96'(0));
    step();
    drive_beat(p[0], w); chk("first_beat_after_pop", 96'(w), 96'(0));
    drive_beat(p[1], w); drive_beat(p[2], w);
    step();
    chk("early_data_done", 96'(exp_q[3].size()), 96'(0));

    // Overflow: FSM parked in FWD, then 5 pulses into a 4-deep FIFO
    begin
      int   sels [6] = '{0, 1, 2, 3, 0, 1};
      pkt_t pk [5];
      for (int k = 0; k < 5; k++) begin mk_pkt($urandom_range(1, 3), pk[k]); expect_pkt(sels[k], pk[k]); end
      md_pulse(sels[0]); step();
      for (int k = 1; k < 6; k++) begin
        md_in = {8'(sels[k]), 8'($urandom)}; md_in_valid = 1;
        @(negedge clk); chk($sformatf("md_overflow_pulse%0d", k), 96'(md_overflow), 96'(k == 5));
        step();
      end
      md_in_valid = 0;
      for (int k = 0; k < 5; k++) drive_pkt(pk[k], 0);
      repeat (3) step();
      chk("ovf_count", 96'(ovf_seen), 96'(1));
      chk("ovf_in_order", 96'(pending()), 96'(0));
      chk("ovf_stall_after", 96'(s_tready), 96'(0));
    end

    // Randomized traffic with random backpressure
    port_enable = 4'b1011; rdy_rand = 1;
    repeat (40) send_rand();
    rdy_rand = 0; m_tready = '1; port_enable = '1;
    repeat (4) step();
    chk("rand_all_delivered", 96'(pending()), 96'(0));
    chk("rand_drop_count", 96'(drop_count), 96'(exp_drops));
    chk("rand_drop_pulses", 96'(drop_seen), 96'(exp_drops));

    // Backpressure on port 1 mid-packet, then reset mid-packet
    base = obs_cnt[1];
    mk_pkt(4, p); expect_pkt(1, p);
    md_pulse(1); step();
    drive_beat(p[0], w); chk("bp_first", 96'(w), 96'(0));
    m_tready = 4'b1101;
    s_tvalid = 1; s_tdata = p[1].d; s_tkeep = p[1].k; s_tlast = p[1].l;
    repeat (3) begin
      @(negedge clk);
      chk("bp_s_tready", 96'(s_tready), 96'(0));
      chk("bp_m_tvalid", 96'(m_tvalid), 96'(4'b0010));
      step();
    end
    m_tready = '1;
    drive_beat(p[1], w); chk("bp_resume", 96'(w), 96'(0));
    drive_beat(p[2], w);
    chk("bp_beats", 96'(obs_cnt[1] - base), 96'(3));
    s_tvalid = 1; s_tdata = p[3].d; s_tkeep = p[3].k; s_tlast = p[3].l;
    #2 aresetn = 0; #1;
    chk("midrst_s_tready", 96'(s_tready), 96'(0));
    chk("midrst_m_tvalid", 96'(m_tvalid), 96'(0));
    chk("midrst_drop_count", 96'(drop_count), 96'(0));
    chk("midrst_drop_pulse", 96'(drop_pulse), 96'(0));
    chk("midrst_md_overflow", 96'(md_overflow), 96'(0));
    for (int i = 0; i < NP; i++) exp_q[i] = {};
    step(); step(); aresetn = 1;
    repeat (3) begin
      @(negedge clk);
      chk("postrst_fifo_empty", 96'(s_tready), 96'(0));
      chk("postrst_m_tvalid", 96'(m_tvalid), 96'(0));
      step();
    end
    s_tvalid = 0; s_tlast = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
